// File: rtl/sipo_matrix_loader_hs.sv
// rtl/sipo_matrix_loader_hs.sv - stream-to-storage loader for GEMM operands A (MxK) and B (KxN)
//
// Purpose: accepts row-major 32-bit words over a valid/ready stream into the A or B store.
//   Dimensions are latched per load command, and every write is bounded by the active matrix
//   size. Both stores are read back through one registered read port. The block also provides
//   word counters, full flags, sticky error flags and a one-cycle done pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   M_in/K_in/N_in           requested dimensions, sampled on an accepted load command
//   cmd, cmd_valid           00 clear, 01 load A, 10 load B, 11 finish
//   s_data/s_valid/s_ready   input word stream
//   rd_sel, rd_addr, rd_data read port (0=A, 1=B), 1-cycle latency
//   M_val/K_val/N_val        latched dimensions
//   a_count/b_count          words written; a_full/b_full matrix complete
//   busy, done               loading; finish accepted with both matrices full
//   err_dim/err_ovf/err_inc  sticky: bad dimensions / dropped word / incomplete finish
module sipo_matrix_loader_hs #(
  parameter int DATA_W = 32,
  parameter int MAX_M  = 16,
  parameter int MAX_K  = 16,
  parameter int MAX_N  = 16,
  parameter int DW_M   = $clog2(MAX_M) + 1,
  parameter int DW_K   = $clog2(MAX_K) + 1,
  parameter int DW_N   = $clog2(MAX_N) + 1,
  parameter int AW_A   = $clog2(MAX_M * MAX_K),
  parameter int AW_B   = $clog2(MAX_K * MAX_N),
  parameter int RA_W   = (AW_A > AW_B) ? AW_A : AW_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW_M-1:0]   M_in,
  input  logic [DW_K-1:0]   K_in,
  input  logic [DW_N-1:0]   N_in,
  input  logic [1:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              rd_sel,
  input  logic [RA_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DW_M-1:0]   M_val,
  output logic [DW_K-1:0]   K_val,
  output logic [DW_N-1:0]   N_val,
  output logic [AW_A:0]     a_count,
  output logic [AW_B:0]     b_count,
  output logic              a_full,
  output logic              b_full,
  output logic              busy,
  output logic              done,
  output logic              err_dim,
  output logic              err_ovf,
  output logic              err_inc
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_A = 2'd1;
  localparam logic [1:0] ST_LOAD_B = 2'd2;

  localparam int PA_W = DW_M + DW_K;
  localparam int PB_W = DW_K + DW_N;
  localparam int CW   = RA_W + 1;

  localparam logic [DW_M-1:0] MAX_M_V = DW_M'(MAX_M);
  localparam logic [DW_K-1:0] MAX_K_V = DW_K'(MAX_K);
  localparam logic [DW_N-1:0] MAX_N_V = DW_N'(MAX_N);

  logic [1:0]        state_q, state_d;
  logic [DW_M-1:0]   m_q, m_d;
  logic [DW_K-1:0]   k_q, k_d;
  logic [DW_N-1:0]   n_q, n_d;
  logic [AW_A:0]     a_cnt_q, a_cnt_d;
  logic [AW_B:0]     b_cnt_q, b_cnt_d;
  logic              a_full_q, a_full_d, b_full_q, b_full_d;
  logic              err_dim_q, err_dim_d, err_ovf_q, err_ovf_d, err_inc_q, err_inc_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_a, wr_b;

  logic [DATA_W-1:0] mem_a [0:MAX_M*MAX_K-1];
  logic [DATA_W-1:0] mem_b [0:MAX_K*MAX_N-1];

  // Full-width products so a 16x16 matrix (256 words) never wraps.
  logic [PA_W-1:0] prod_a;
  logic [PB_W-1:0] prod_b;
  assign prod_a = PA_W'(m_q) * PA_W'(k_q);
  assign prod_b = PB_W'(k_q) * PB_W'(n_q);

  logic m_ok, k_ok, n_ok;
  assign m_ok = (M_in != '0) && (M_in <= MAX_M_V);
  assign k_ok = (K_in != '0) && (K_in <= MAX_K_V);
  assign n_ok = (N_in != '0) && (N_in <= MAX_N_V);

  assign s_ready = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    k_d       = k_q;
    n_d       = n_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    a_full_d  = a_full_q;
    b_full_d  = b_full_q;
    err_dim_d = err_dim_q;
    err_ovf_d = err_ovf_q;
    err_inc_d = err_inc_q;
    done_d    = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;

    if (s_valid && !s_ready) err_ovf_d = 1'b1;

    case (state_q)
      ST_LOAD_A: begin
        if (s_valid) begin
          wr_a    = 1'b1;
          a_cnt_d = a_cnt_q + 1'b1;
          if (PA_W'(a_cnt_d) == prod_a) begin
            a_full_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_LOAD_B: begin
        if (s_valid) begin
          wr_b    = 1'b1;
          b_cnt_d = b_cnt_q + 1'b1;
          if (PB_W'(b_cnt_d) == prod_b) begin
            b_full_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            2'b01: begin
              if (m_ok && k_ok) begin
                m_d      = M_in;
                k_d      = K_in;
                a_cnt_d  = '0;
                a_full_d = 1'b0;
                state_d  = ST_LOAD_A;
              end else begin
                err_dim_d = 1'b1;
              end
            end
            2'b10: begin
              if (k_ok && n_ok) begin
                // A loaded with a different K can no longer be multiplied by this B.
                if (a_full_q && (K_in != k_q)) err_dim_d = 1'b1;
                k_d      = K_in;
                n_d      = N_in;
                b_cnt_d  = '0;
                b_full_d = 1'b0;
                state_d  = ST_LOAD_B;
              end else begin
                err_dim_d = 1'b1;
              end
            end
            2'b11: begin
              if (a_full_q && b_full_q) done_d = 1'b1;
              else                      err_inc_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear wins over everything, in any state; dimensions are intentionally kept.
    if (cmd_valid && (cmd == 2'b00)) begin
      state_d   = ST_IDLE;
      a_cnt_d   = '0;
      b_cnt_d   = '0;
      a_full_d  = 1'b0;
      b_full_d  = 1'b0;
      err_dim_d = 1'b0;
      err_ovf_d = 1'b0;
      err_inc_d = 1'b0;
    end

    // Gate on the pre-write count: unwritten or stale words read as 0.
    rd_data_d = '0;
    if (rd_sel) begin
      if (CW'(rd_addr) < CW'(b_cnt_q)) rd_data_d = mem_b[rd_addr[AW_B-1:0]];
    end else begin
      if (CW'(rd_addr) < CW'(a_cnt_q)) rd_data_d = mem_a[rd_addr[AW_A-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      k_q       <= '0;
      n_q       <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      a_full_q  <= 1'b0;
      b_full_q  <= 1'b0;
      err_dim_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_inc_q <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      k_q       <= k_d;
      n_q       <= n_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      a_full_q  <= a_full_d;
      b_full_q  <= b_full_d;
      err_dim_q <= err_dim_d;
      err_ovf_q <= err_ovf_d;
      err_inc_q <= err_inc_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is not reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (wr_a && !rst) mem_a[a_cnt_q[AW_A-1:0]] <= s_data;
    if (wr_b && !rst) mem_b[b_cnt_q[AW_B-1:0]] <= s_data;
  end

  assign rd_data = rd_data_q;
  assign M_val   = m_q;
  assign K_val   = k_q;
  assign N_val   = n_q;
  assign a_count = a_cnt_q;
  assign b_count = b_cnt_q;
  assign a_full  = a_full_q;
  assign b_full  = b_full_q;
  assign busy    = s_ready;
  assign done    = done_q;
  assign err_dim = err_dim_q;
  assign err_ovf = err_ovf_q;
  assign err_inc = err_inc_q;

endmodule
